clb_config_loader: RTL
======================

// Module: clb_config_loader
// PURPOSE
//  Configuration master for a serial chain of CLBModule instances.
//  - Accepts parallel configuration frames over a valid/ready handshake.
//  - Serialises each frame onto the chain's prog_in/prog_en pins.
//  - Runs in the prog_clk domain and drives the head of the chain.
//  - The first frame sent ends up in the farthest CLB; the last frame stays
//    in the CLB nearest this block.
// PARAMETERS
//  FRAME_W     17  bits per CLB frame: bit0 = output-mux select, bits[16:1] = LUT truth table
//  NUM_FRAMES  4   number of CLBs in the chain (frames per load), >=1
//  CNT_W       $clog2(NUM_FRAMES+1)  width of frames_loaded
// PORTS
//  prog_clk       in   1          configuration clock, shared with the CLB chain
//  prog_rst       in   1          asynchronous, active-high reset
//  start          in   1          begin a load; sampled only in IDLE
//  abort          in   1          synchronous cancel of a load in progress
//  frame_data     in   FRAME_W    frame word; bit0 is shifted out first
//  frame_valid    in   1          frame_data is valid
//  frame_ready    out  1          loader accepts frame_data this cycle
//  prog_data      out  1          to prog_in of CLB 0 (chain head)
//  prog_en        out  1          to prog_en of every CLB in the chain
//  busy           out  1          high in any state other than IDLE
//  done           out  1          one-cycle pulse after the last bit is launched
//  frames_loaded  out  CNT_W      frames fully shifted in the current or last load
// BEHAVIOUR
//  Reset (async, prog_rst=1):
//  - State IDLE; prog_data, prog_en, done and frames_loaded all 0.
//  - Internal shift register and counters are cleared.
//  Outputs:
//  - prog_data, prog_en, done and frames_loaded are registered.
//  - busy and frame_ready are decoded combinationally from state and counters.
//  States: IDLE, WAIT_FRAME, SHIFT, DONE.
//  IDLE:
//  - start=1 -> WAIT_FRAME; frames_loaded <= 0.
//  - start is ignored in every other state.
//  WAIT_FRAME:
//  - frame_ready=1; prog_en<=0, so the chain holds its contents.
//  - On frame_valid&frame_ready: shreg <= frame_data>>1, prog_data <= frame_data[0],
//    prog_en <= 1, bit_cnt <= 1, then go to SHIFT.
//  SHIFT:
//  - While bit_cnt < FRAME_W: prog_data <= shreg[0], shreg >>= 1, bit_cnt++, prog_en stays 1.
//  - When bit_cnt == FRAME_W, the frame is complete:
//    - frames_loaded increments.
//    - If this is not the last frame, frame_ready=1 in this same cycle (gapless back-to-back).
//      - frame accepted: launch its bit0 exactly as in WAIT_FRAME and stay in SHIFT.
//      - no frame: prog_en <= 0 and go to WAIT_FRAME.
//    - If this is the last frame: prog_en <= 0 and go to DONE.
//  DONE: done <= 1 for one cycle, then IDLE.
//  Chain contract:
//  - Each cycle prog_en=1 is held corresponds to exactly one CLB shift on the next prog_clk edge.
//  - A full load is exactly NUM_FRAMES*FRAME_W prog_en-high cycles.
//  Latency:
//  - Edge 1: start sampled.
//  - Edge 2: first frame accepted, if valid is already high.
//  - With gapless frames, prog_en is high for FRAME_W*NUM_FRAMES cycles, then done pulses.
//  abort (any non-IDLE state):
//  - Next edge: IDLE, prog_en <= 0, no done pulse.
//  - frames_loaded holds its value; any partial frame is left in the chain.
//  abort and start in the same IDLE cycle: abort wins and the load does not start.
//  frame_valid with frame_ready=0: ignored; no data is consumed.
//  Reset mid-shift: prog_en drops immediately (async).
// TESTING
//  - Reset mid-load: assert prog_rst during SHIFT -> prog_en=0, busy=0 and frames_loaded=0 immediately.
//  - Single frame, NUM_FRAMES=1, frame 17'h1_0001 -> prog_en high for 17 cycles.
//    - prog_data sequence is 1, fifteen 0s, then 1.
//    - CLB shift_reg == 17'h1_0001 afterwards; done pulses once.
//  - Gapless load of 4 frames A,B,C,D into a 4-CLB chain model:
//    - 68 contiguous prog_en cycles.
//    - CLB3=A, CLB2=B, CLB1=C, CLB0=D.
//    - frames_loaded ends at 4.
//  - Stalled source: drop frame_valid for 5 cycles after frame 2.
//    - prog_en=0 for those cycles; the chain contents are unchanged.
//    - The final image is identical to the gapless case.
//  - abort on bit 9 of frame 3 -> next edge prog_en=0, IDLE, frames_loaded=2, done never pulses.
//  - start while busy is ignored; start+abort in IDLE -> the loader stays in IDLE.

Source files
------------

// File: rtl/clb_config_loader.sv
// -----------------------------------------------------------------------------
// clb_config_loader
//
// Configuration master for a serial chain of CLBs. It accepts parallel frames
// over a valid/ready handshake and shifts each one, LSB first, into the head
// of the chain on prog_data/prog_en. The first frame of a load travels to the
// farthest CLB. The last frame stays in the CLB nearest this block.
//
// Ports
//   prog_clk       configuration clock, shared with the CLB chain
//   prog_rst       asynchronous, active-high reset
//   start          begin a load (sampled only in IDLE)
//   abort          synchronous cancel of a load in progress
//   frame_data     frame word, bit0 is shifted out first
//   frame_valid    frame_data is valid
//   frame_ready    loader accepts frame_data this cycle (combinational)
//   prog_data      serial data to prog_in of CLB 0 (registered)
//   prog_en        shift enable to every CLB (registered)
//   busy           high whenever the FSM is not IDLE (combinational)
//   done           one-cycle pulse after the last bit of a load (registered)
//   frames_loaded  frames fully shifted in the current/last load (registered)
// -----------------------------------------------------------------------------
module clb_config_loader #(
    parameter int FRAME_W    = 17,
    parameter int NUM_FRAMES = 4,
    parameter int CNT_W      = $clog2(NUM_FRAMES + 1)
) (
    input  logic               prog_clk,
    input  logic               prog_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic               prog_data,
    output logic               prog_en,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   frames_loaded
);

    localparam int BIT_W = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SHIFT      = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               prog_data_q, prog_data_d;
    logic               prog_en_q, prog_en_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   frames_loaded_q, frames_loaded_d;

    logic frame_end;
    logic last_frame;
    logic accept;

    // bit_cnt counts bits already placed on prog_data. When it reaches
    // FRAME_W the final bit of the frame is on the pins this cycle and
    // will be taken by the chain at the coming edge.
    assign frame_end  = (state_q == SHIFT) && (bit_cnt_q == BIT_W'(FRAME_W));
    assign last_frame = (frames_loaded_q == CNT_W'(NUM_FRAMES - 1));

    // Ready in the completion cycle of a non-final frame lets the next
    // frame's bit0 follow the previous bit16 with no idle cycle.
    // abort is not folded in: a frame offered alongside abort is dropped
    // together with the rest of the cancelled load.
    assign frame_ready = (state_q == WAIT_FRAME) || (frame_end && !last_frame);
    assign accept      = frame_valid && frame_ready;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d         = state_q;
        shreg_d         = shreg_q;
        bit_cnt_d       = bit_cnt_q;
        prog_data_d     = prog_data_q;
        prog_en_d       = prog_en_q;
        done_d          = 1'b0;
        frames_loaded_d = frames_loaded_q;

        if (abort && state_q != IDLE) begin
            // Partial frame stays in the chain; frames_loaded keeps its count.
            state_d   = IDLE;
            prog_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    prog_en_d = 1'b0;
                    // abort in the same cycle suppresses the start.
                    if (start && !abort) begin
                        state_d         = WAIT_FRAME;
                        frames_loaded_d = '0;
                    end
                end

                WAIT_FRAME: begin
                    prog_en_d = 1'b0;
                    if (accept) begin
                        shreg_d     = frame_data >> 1;
                        prog_data_d = frame_data[0];
                        prog_en_d   = 1'b1;
                        bit_cnt_d   = BIT_W'(1);
                        state_d     = SHIFT;
                    end
                end

                SHIFT: begin
                    if (!frame_end) begin
                        prog_data_d = shreg_q[0];
                        shreg_d     = shreg_q >> 1;
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        prog_en_d   = 1'b1;
                    end else begin
                        frames_loaded_d = frames_loaded_q + 1'b1;
                        if (last_frame) begin
                            prog_en_d = 1'b0;
                            state_d   = DONE;
                        end else if (accept) begin
                            shreg_d     = frame_data >> 1;
                            prog_data_d = frame_data[0];
                            prog_en_d   = 1'b1;
                            bit_cnt_d   = BIT_W'(1);
                        end else begin
                            prog_en_d = 1'b0;
                            state_d   = WAIT_FRAME;
                        end
                    end
                end

                DONE: begin
                    prog_en_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end

                default: begin
                    prog_en_d = 1'b0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            state_q         <= IDLE;
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            prog_data_q     <= 1'b0;
            prog_en_q       <= 1'b0;
            done_q          <= 1'b0;
            frames_loaded_q <= '0;
        end else begin
            state_q         <= state_d;
            shreg_q         <= shreg_d;
            bit_cnt_q       <= bit_cnt_d;
            prog_data_q     <= prog_data_d;
            prog_en_q       <= prog_en_d;
            done_q          <= done_d;
            frames_loaded_q <= frames_loaded_d;
        end
    end

    assign prog_data     = prog_data_q;
    assign prog_en       = prog_en_q;
    assign done          = done_q;
    assign frames_loaded = frames_loaded_q;

endmodule
